// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity, framing and break handling.
// Optional 3-sample majority vote per bit when UART_RX_MAJORITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk2,
    input  logic                  rst,
    input  logic                  data,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  valid_data,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] SAMP = CW'(PRESCALE / 2);
`else
    localparam logic [CW-1:0] SAMP = CW'(PRESCALE / 2 - 1);
`endif
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q;
    logic [1:0]            sync_q;
    logic [CW-1:0]         edge_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  armed_q;
    logic                  pen_q;
    logic                  ptype_q;
    logic                  pfail_q;
    logic                  sfail_q;

    logic line;
    logic bit_s;
    logic samp;
    logic wrap;
    logic sfail_now;

    assign line      = sync_q[1];
    assign samp      = (edge_cnt_q == SAMP);
    assign wrap      = (edge_cnt_q == LAST);
    assign sfail_now = sfail_q | ~bit_s;

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], data};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q;

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            vote_q <= 2'b00;
        end else if (edge_cnt_q == CW'(PRESCALE / 2 - 2)) begin
            vote_q[0] <= line;
        end else if (edge_cnt_q == CW'(PRESCALE / 2 - 1)) begin
            vote_q[1] <= line;
        end
    end

    assign bit_s = (vote_q[0] & vote_q[1]) | (vote_q[0] & line) | (vote_q[1] & line);
`else
    assign bit_s = line;
`endif

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            armed_q    <= 1'b0;
            pen_q      <= 1'b0;
            ptype_q    <= 1'b0;
            pfail_q    <= 1'b0;
            sfail_q    <= 1'b0;
            p_data     <= '0;
            valid_data <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid_data <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state_q != S_IDLE) begin
                edge_cnt_q <= wrap ? '0 : edge_cnt_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    armed_q <= line;
                    // Only a high-to-low transition starts a frame, so a break never retriggers
                    if (armed_q && !line) begin
                        state_q    <= S_START;
                        armed_q    <= 1'b0;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        busy       <= 1'b1;
                        pen_q      <= parity_en;
                        ptype_q    <= parity_type;
                        pfail_q    <= 1'b0;
                        sfail_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (samp && bit_s) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (wrap) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (samp) begin
                        shift_q <= {bit_s, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (wrap) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= pen_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (samp) begin
                        pfail_q <= ((^shift_q) ^ bit_s) != ~ptype_q;
                    end
                    if (wrap) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (samp) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            // Leave mid-bit so a start edge late in the stop bit is caught
                            state_q    <= S_IDLE;
                            busy       <= 1'b0;
                            valid_data <= !pfail_q && !sfail_now;
                            par_err    <= pfail_q;
                            stp_err    <= sfail_now;
                            if (!pfail_q && !sfail_now) begin
                                p_data <= shift_q;
                            end
                        end else begin
                            sfail_q <= sfail_now;
                        end
                    end
                    if (wrap) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int W = 8;
    localparam int P = 16;
    localparam int S = 1;

    logic         clk2 = 1'b0;
    logic         rst;
    logic         data;
    logic         parity_en;
    logic         parity_type;
    logic [W-1:0] p_data;
    logic         valid_data;
    logic         par_err;
    logic         stp_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_par    = 0;
    int n_stp    = 0;
    int n_rise   = 0;
    logic busy_prev = 1'b0;

    uart_rx_param #(.DATA_WIDTH(W), .PRESCALE(P), .STOP_BITS(S)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .data       (data),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .p_data     (p_data),
        .valid_data (valid_data),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #1.25 clk2 = ~clk2;

    always @(negedge clk2) begin
        if (valid_data) n_valid++;
        if (par_err) n_par++;
        if (stp_err) n_stp++;
        if (busy && !busy_prev) n_rise++;
        busy_prev = busy;
    end

    // Frame outcome from the protocol rules: count ones, check stop level.
    function automatic void model(input logic [W-1:0] d, input logic pen,
                                  input logic ptype, input logic pbit,
                                  input logic stopv, output logic ev,
                                  output logic ep, output logic es);
        int ones;
        logic pok;
        ones = $countones(d) + int'(pbit);
        pok  = !pen || (ptype ? (ones % 2 == 0) : (ones % 2 == 1));
        ev   = pok && stopv;
        ep   = !pok;
        es   = !stopv;
    endfunction

    task automatic idle(input int n);
        data = 1'b1;
        repeat (n) @(negedge clk2);
    endtask

    task automatic send_bit(input logic b, input logic g);
        for (int c = 0; c < P; c++) begin
            data = (g && c == P / 2 - 1) ? ~b : b;
            @(negedge clk2);
        end
    endtask

    // Leaves the line at the stop level; caller decides what follows.
    task automatic send_frame(input logic [W-1:0] d, input logic pen,
                              input logic ptype, input logic pbit,
                              input logic stopv, input int gbit,
                              input logic scramble);
        parity_en   = pen;
        parity_type = ptype;
        send_bit(1'b0, 1'b0);
        if (scramble) begin
            parity_en   = 1'($urandom);
            parity_type = 1'($urandom);
        end
        for (int i = 0; i < W; i++) send_bit(d[i], i == gbit);
        if (pen) send_bit(pbit, 1'b0);
        for (int i = 0; i < S; i++) send_bit(stopv, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data = 1'b1;
        parity_en = 1'b0;
        parity_type = 1'b0;
        repeat (4) @(negedge clk2);
        if (p_data !== '0) begin
            n_fail++;
            $display("FAIL reset_pdata got %h want 00", p_data);
        end
        n_checks++;
        if ({valid_data, par_err, stp_err, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000",
                     {valid_data, par_err, stp_err, busy});
        end
        n_checks++;
        rst = 1'b1;
        idle(P);
    endtask

    task automatic test_directed();
        logic [W-1:0] td [3] = '{8'hFF, 8'h0F, 8'hFD};
        logic         tt [3] = '{1'b1, 1'b0, 1'b1};
        logic         tp [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] tx [3] = '{8'hFF, 8'h0F, 8'h0F};
        logic [2:0]   tf [3] = '{3'b100, 3'b100, 3'b010};
        int v0, p0, s0;
        for (int k = 0; k < 3; k++) begin
            v0 = n_valid; p0 = n_par; s0 = n_stp;
            send_frame(td[k], 1'b1, tt[k], tp[k], 1'b1, -1, 1'b0);
            idle(P);
            if ({3'(n_valid - v0), 3'(n_par - p0), 3'(n_stp - s0)} !==
                {2'b0, tf[k][2], 2'b0, tf[k][1], 2'b0, tf[k][0]}) begin
                n_fail++;
                $display("FAIL directed%0d_pulses got v%0d p%0d s%0d want %b",
                         k, n_valid - v0, n_par - p0, n_stp - s0, tf[k]);
            end
            n_checks++;
            if (p_data !== tx[k]) begin
                n_fail++;
                $display("FAIL directed%0d_pdata got %h want %h", k, p_data, tx[k]);
            end
            n_checks++;
        end
    endtask

    task automatic test_glitch();
        int v0, p0, s0, r0;
        v0 = n_valid; p0 = n_par; s0 = n_stp; r0 = n_rise;
        data = 1'b0;
        repeat (4) @(negedge clk2);
        data = 1'b1;
        repeat (P) @(negedge clk2);
        if (n_rise - r0 !== 1) begin
            n_fail++;
            $display("FAIL glitch_busy_seen got %0d rises want 1", n_rise - r0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_end got %b want 0", busy);
        end
        n_checks++;
        if ((n_valid - v0) + (n_par - p0) + (n_stp - s0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses got %0d want 0",
                     (n_valid - v0) + (n_par - p0) + (n_stp - s0));
        end
        n_checks++;
        idle(P);
    endtask

    task automatic test_break();
        int v0, s0, r0;
        v0 = n_valid; s0 = n_stp;
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        r0 = n_rise;
        data = 1'b0;
        repeat (20 * P) @(negedge clk2);
        if (n_stp - s0 !== 1 || n_valid - v0 !== 0) begin
            n_fail++;
            $display("FAIL break_stp got s%0d v%0d want s1 v0",
                     n_stp - s0, n_valid - v0);
        end
        n_checks++;
        if (n_rise - r0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_retrigger got %0d rises busy %b want 0 0",
                     n_rise - r0, busy);
        end
        n_checks++;
        idle(2 * P);
        v0 = n_valid;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        idle(P);
        if (n_valid - v0 !== 1 || p_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL break_recover got v%0d pdata %h want v1 3c",
                     n_valid - v0, p_data);
        end
        n_checks++;
    endtask

    task automatic test_abort();
        logic [W-1:0] d = 8'hA5;
        int v0, p0, s0, gb;
        parity_en = 1'b1;
        parity_type = 1'b1;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
        data = d[4];
        repeat (P / 2) @(negedge clk2);
        rst = 1'b0;
        repeat (3) @(negedge clk2);
        data = 1'b1;
        if (p_data !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset got pdata %h busy %b want 00 0", p_data, busy);
        end
        n_checks++;
        rst = 1'b1;
        v0 = n_valid; p0 = n_par; s0 = n_stp;
        idle(4 * P);
        if ((n_valid - v0) + (n_par - p0) + (n_stp - s0) !== 0) begin
            n_fail++;
            $display("FAIL abort_no_pulse got %0d want 0",
                     (n_valid - v0) + (n_par - p0) + (n_stp - s0));
        end
        n_checks++;
`ifdef UART_RX_MAJORITY_EN
        gb = 2;
`else
        gb = -1;
`endif
        for (int rep = 0; rep < 2; rep++) begin
            v0 = n_valid;
            send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1, rep == 1 ? gb : -1, 1'b0);
            idle(P);
            if (n_valid - v0 !== 1 || p_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL abort_frame%0d got v%0d pdata %h want v1 a5",
                         rep, n_valid - v0, p_data);
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic [W-1:0] exp_p;
        logic pen, ptype, pbit, stopv, ev, ep, es;
        int v0, p0, s0, ones;
        exp_p = p_data;
        for (int k = 0; k < 40; k++) begin
            d     = W'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            ones  = $countones(d);
            pbit  = 1'(ptype ? ones % 2 : (ones + 1) % 2);
            if ($urandom_range(0, 4) == 0) pbit = ~pbit;
            stopv = ($urandom_range(0, 4) != 0);
            model(d, pen, ptype, pen ? pbit : 1'b0, stopv, ev, ep, es);
            if (ev) exp_p = d;
            v0 = n_valid; p0 = n_par; s0 = n_stp;
            send_frame(d, pen, ptype, pbit, stopv, -1, 1'b1);
            idle($urandom_range(P, 3 * P));
            if ({n_valid - v0, n_par - p0, n_stp - s0} !==
                {int'(ev), int'(ep), int'(es)}) begin
                n_fail++;
                $display("FAIL rand%0d_pulses d=%h pen=%b pt=%b pb=%b st=%b got v%0d p%0d s%0d want v%0d p%0d s%0d",
                         k, d, pen, ptype, pbit, stopv, n_valid - v0,
                         n_par - p0, n_stp - s0, ev, ep, es);
            end
            n_checks++;
            if (p_data !== exp_p) begin
                n_fail++;
                $display("FAIL rand%0d_pdata got %h want %h", k, p_data, exp_p);
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_glitch();
        test_break();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
